// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage with req/ack data memory port and registered MEM/WB bundle
module mem_stage #(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic [15:0]       PC_in,
    input  logic [31:0]       ALURes_in,
    input  logic [31:0]       StoreData_in,
    input  logic [2:0]        WriteReg_in,
    input  logic              write_en_in,
    input  logic              MemRead_in,
    input  logic              MemWrite_in,
    output logic              stall_out,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              valid_out,
    output logic [15:0]       PC_out,
    output logic [31:0]       ALURes_out,
    output logic [31:0]       MemReadData_out,
    output logic [2:0]        WriteReg_out,
    output logic              write_en_out,
    output logic              MemRead_out,
    output logic              mem_err
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic             memop;
    logic             timeout_hit;
    logic             stall_int;

    // Copy of the instruction taken at issue so the retire does not depend
    // on upstream keeping its inputs stable through the abort cycle.
    logic [15:0]      hold_pc;
    logic [31:0]      hold_alu;
    logic [2:0]       hold_wreg;
    logic             hold_we;
    logic             hold_mr;

    assign memop       = valid_in & (MemRead_in | MemWrite_in);
    // Ack has priority over the timeout in the same cycle.
    assign timeout_hit = (state == ACCESS) && !mem_ack && (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        stall_int = 1'b0;
        case (state)
            IDLE: begin
                if (memop) begin
                    state_nx  = ACCESS;
                    stall_int = 1'b1;
                end
            end
            ACCESS: begin
                stall_int = ~mem_ack & ~timeout_hit;
                if (mem_ack || timeout_hit) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // No stall while in reset so upstream is not frozen by a pending memop.
    assign stall_out = rst_n & stall_int;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_req         <= 1'b0;
            mem_we          <= 1'b0;
            mem_addr        <= '0;
            mem_wdata       <= '0;
            cnt             <= '0;
            valid_out       <= 1'b0;
            PC_out          <= '0;
            ALURes_out      <= '0;
            MemReadData_out <= '0;
            WriteReg_out    <= '0;
            write_en_out    <= 1'b0;
            MemRead_out     <= 1'b0;
            mem_err         <= 1'b0;
            hold_pc         <= '0;
            hold_alu        <= '0;
            hold_wreg       <= '0;
            hold_we         <= 1'b0;
            hold_mr         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!valid_in) begin
                        valid_out    <= 1'b0;
                        write_en_out <= 1'b0;
                    end else if (!memop) begin
                        valid_out    <= 1'b1;
                        PC_out       <= PC_in;
                        ALURes_out   <= ALURes_in;
                        WriteReg_out <= WriteReg_in;
                        write_en_out <= write_en_in;
                        MemRead_out  <= MemRead_in;
                    end else begin
                        mem_req      <= 1'b1;
                        mem_we       <= MemWrite_in & ~MemRead_in;
                        mem_addr     <= ALURes_in[ADDR_W-1:0];
                        mem_wdata    <= StoreData_in;
                        cnt          <= '0;
                        valid_out    <= 1'b0;
                        write_en_out <= 1'b0;
                        hold_pc      <= PC_in;
                        hold_alu     <= ALURes_in;
                        hold_wreg    <= WriteReg_in;
                        hold_we      <= write_en_in;
                        hold_mr      <= MemRead_in;
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        mem_req      <= 1'b0;
                        valid_out    <= 1'b1;
                        PC_out       <= hold_pc;
                        ALURes_out   <= hold_alu;
                        WriteReg_out <= hold_wreg;
                        write_en_out <= hold_we;
                        MemRead_out  <= hold_mr;
                        if (!mem_we) MemReadData_out <= mem_rdata;
                    end else if (timeout_hit) begin
                        // Abort: retire without a register write, flag the error.
                        mem_req      <= 1'b0;
                        mem_err      <= 1'b1;
                        valid_out    <= 1'b1;
                        PC_out       <= hold_pc;
                        ALURes_out   <= hold_alu;
                        WriteReg_out <= hold_wreg;
                        write_en_out <= 1'b0;
                        MemRead_out  <= hold_mr;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard testbench for mem_stage
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic [15:0] PC_in;
    logic [31:0] ALURes_in;
    logic [31:0] StoreData_in;
    logic [2:0]  WriteReg_in;
    logic        write_en_in;
    logic        MemRead_in;
    logic        MemWrite_in;
    logic        stall_out;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        valid_out;
    logic [15:0] PC_out;
    logic [31:0] ALURes_out;
    logic [31:0] MemReadData_out;
    logic [2:0]  WriteReg_out;
    logic        write_en_out;
    logic        MemRead_out;
    logic        mem_err;

    mem_stage #(.ADDR_W(16), .TIMEOUT(4), .CNT_W(7)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .PC_in(PC_in),
        .ALURes_in(ALURes_in), .StoreData_in(StoreData_in), .WriteReg_in(WriteReg_in),
        .write_en_in(write_en_in), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
        .stall_out(stall_out), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .valid_out(valid_out), .PC_out(PC_out), .ALURes_out(ALURes_out),
        .MemReadData_out(MemReadData_out), .WriteReg_out(WriteReg_out),
        .write_en_out(write_en_out), .MemRead_out(MemRead_out), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic [31:0] alu;
        logic [31:0] mrd;
        logic [2:0]  wr;
        logic        we;
        logic        mr;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] pc, input logic [31:0] alu, input logic [31:0] mrd,
                        input logic [2:0] wr, input logic we, input logic mr);
        exp_t e;
        e.pc = pc; e.alu = alu; e.mrd = mrd; e.wr = wr; e.we = we; e.mr = mr;
        q.push_back(e);
    endtask

    task automatic drive(input logic v, input logic [15:0] pc, input logic [31:0] alu,
                         input logic [31:0] sd, input logic [2:0] wr, input logic we,
                         input logic mr, input logic mw);
        valid_in = v; PC_in = pc; ALURes_in = alu; StoreData_in = sd;
        WriteReg_in = wr; write_en_in = we; MemRead_in = mr; MemWrite_in = mw;
    endtask

    // Monitor: every retire is matched against the oldest expected bundle.
    always @(negedge clk) begin
        if (valid_out === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_retire", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("PC_out", {16'd0, PC_out}, {16'd0, e.pc});
                chk("ALURes_out", ALURes_out, e.alu);
                chk("MemReadData_out", MemReadData_out, e.mrd);
                chk("WriteReg_out", {29'd0, WriteReg_out}, {29'd0, e.wr});
                chk("write_en_out", {31'd0, write_en_out}, {31'd0, e.we});
                chk("MemRead_out", {31'd0, MemRead_out}, {31'd0, e.mr});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int stalls;
        int reqc;
        int first_nostall;

        rst_n = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
        drive(1'b1, 16'h0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b1, 1'b0);
        tick();
        tick();
        chk("rst_valid_out", {31'd0, valid_out}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_stall_out", {31'd0, stall_out}, 32'd0);
        chk("rst_mem_err", {31'd0, mem_err}, 32'd0);
        chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        chk("rst_write_en_out", {31'd0, write_en_out}, 32'd0);
        chk("rst_MemReadData_out", MemReadData_out, 32'd0);

        rst_n = 1'b1;
        drive(1'b0, 16'h0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
        tick();

        // ALU op, one-cycle latency
        drive(1'b1, 16'h0010, 32'h12345678, 32'h0, 3'd3, 1'b1, 1'b0, 1'b0);
        #1;
        chk("alu_stall", {31'd0, stall_out}, 32'd0);
        push(16'h0010, 32'h12345678, 32'h0, 3'd3, 1'b1, 1'b0);
        tick();
        chk("alu_valid_next", {31'd0, valid_out}, 32'd1);
        drive(1'b0, 16'h0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("bubble_valid", {31'd0, valid_out}, 32'd0);

        // Load with ack on the fourth ACCESS cycle (also coincides with the timeout count)
        drive(1'b1, 16'h0020, 32'h0000ABCD, 32'h0, 3'd5, 1'b1, 1'b1, 1'b0);
        mem_rdata = 32'hDEADBEEF;
        push(16'h0020, 32'h0000ABCD, 32'hDEADBEEF, 3'd5, 1'b1, 1'b1);
        stalls = 0;
        for (int c = 0; c < 5; c++) begin
            mem_ack = (c == 4);
            #1;
            if (stall_out) stalls++;
            if (c == 1) begin
                chk("ld_mem_req", {31'd0, mem_req}, 32'd1);
                chk("ld_mem_addr", {16'd0, mem_addr}, 32'h0000ABCD);
                chk("ld_mem_we", {31'd0, mem_we}, 32'd0);
            end
            tick();
        end
        drive(1'b0, 16'h0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
        mem_ack = 1'b0;
        chk("ld_stall_cycles", stalls, 32'd4);
        chk("ld_req_dropped", {31'd0, mem_req}, 32'd0);
        chk("ld_no_err", {31'd0, mem_err}, 32'd0);
        tick();

        // Store, ack in the first ACCESS cycle
        drive(1'b1, 16'h0030, 32'h00000100, 32'hCAFEF00D, 3'd0, 1'b0, 1'b0, 1'b1);
        push(16'h0030, 32'h00000100, 32'hDEADBEEF, 3'd0, 1'b0, 1'b0);
        tick();
        mem_ack = 1'b1;
        #1;
        chk("st_mem_req", {31'd0, mem_req}, 32'd1);
        chk("st_mem_we", {31'd0, mem_we}, 32'd1);
        chk("st_mem_wdata", mem_wdata, 32'hCAFEF00D);
        chk("st_valid_edge1", {31'd0, valid_out}, 32'd0);
        chk("st_stall_ack", {31'd0, stall_out}, 32'd0);
        tick();
        drive(1'b0, 16'h0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
        mem_ack = 1'b0;
        chk("st_valid_edge2", {31'd0, valid_out}, 32'd1);
        chk("st_req_1cycle", {31'd0, mem_req}, 32'd0);
        tick();

        // Stray ack in IDLE must be ignored
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("idle_ack_req", {31'd0, mem_req}, 32'd0);
        chk("idle_ack_valid", {31'd0, valid_out}, 32'd0);

        // Timeout abort (TIMEOUT=4)
        drive(1'b1, 16'h0040, 32'h00001234, 32'h0, 3'd6, 1'b1, 1'b1, 1'b0);
        push(16'h0040, 32'h00001234, 32'hDEADBEEF, 3'd6, 1'b0, 1'b1);
        tick();
        reqc = 0;
        first_nostall = -1;
        for (int c = 0; c < 7; c++) begin
            if (mem_req) reqc++;
            if (!stall_out && first_nostall < 0) first_nostall = c;
            if (!stall_out) valid_in = 1'b0;
            tick();
        end
        chk("to_req_cycles", reqc, 32'd4);
        chk("to_abort_cycle", first_nostall, 32'd3);
        chk("to_mem_err", {31'd0, mem_err}, 32'd1);

        // Back-to-back: ALU, load, ALU
        drive(1'b1, 16'h0050, 32'h11111111, 32'h0, 3'd1, 1'b1, 1'b0, 1'b0);
        push(16'h0050, 32'h11111111, 32'hDEADBEEF, 3'd1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 16'h0054, 32'h00002000, 32'h0, 3'd2, 1'b1, 1'b1, 1'b0);
        mem_rdata = 32'h0BADF00D;
        push(16'h0054, 32'h00002000, 32'h0BADF00D, 3'd2, 1'b1, 1'b1);
        #1;
        chk("b2b_stall_issue", {31'd0, stall_out}, 32'd1);
        tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("b2b_load_retire", {16'd0, PC_out}, 32'h0054);
        drive(1'b1, 16'h0058, 32'h22222222, 32'h0, 3'd4, 1'b1, 1'b0, 1'b0);
        push(16'h0058, 32'h22222222, 32'h0BADF00D, 3'd4, 1'b1, 1'b0);
        tick();
        drive(1'b0, 16'h0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
        chk("b2b_alu2_next", {16'd0, PC_out}, 32'h0058);
        chk("err_sticky", {31'd0, mem_err}, 32'd1);
        tick();
        tick();

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("err_cleared", {31'd0, mem_err}, 32'd0);
        chk("rst2_valid", {31'd0, valid_out}, 32'd0);
        tick();

        chk("scoreboard_empty", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
